// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel/line counters with run/stop control, decoding
// sync, visibility and frame/line markers from the current count.
module vga_timing_ctrl #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             frame_start,
  output logic             line_end,
  output logic             busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [WIDTH-1:0] H_LAST     = WIDTH'(H_TOTAL - 1);
  localparam logic [WIDTH-1:0] V_LAST     = WIDTH'(V_TOTAL - 1);
  localparam logic [WIDTH-1:0] H_ACT_END  = WIDTH'(H_ACTIVE);
  localparam logic [WIDTH-1:0] V_ACT_END  = WIDTH'(V_ACTIVE);
  localparam logic [WIDTH-1:0] H_SYNC_BEG = WIDTH'(H_ACTIVE + H_FP);
  localparam logic [WIDTH-1:0] H_SYNC_END = WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [WIDTH-1:0] V_SYNC_BEG = WIDTH'(V_ACTIVE + V_FP);
  localparam logic [WIDTH-1:0] V_SYNC_END = WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] h_cnt;
  logic [WIDTH-1:0] v_cnt;
  logic [WIDTH-1:0] h_next;
  logic [WIDTH-1:0] v_next;
  logic             scanning;
  logic             h_wrap;
  logic             v_wrap;
  logic             frame_wrap;

  assign scanning   = (state != IDLE);
  // >= rather than == so an out-of-range count can never run away
  assign h_wrap     = (h_cnt >= H_LAST);
  assign v_wrap     = (v_cnt >= V_LAST);
  assign frame_wrap = en & h_wrap & v_wrap;

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_next;
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  // Next-state and counter advance; start/stop act on any clk, counting only on en
  always_comb begin
    state_next = state;
    h_next     = h_cnt;
    v_next     = v_cnt;

    unique case (state)
      IDLE: begin
        if (start && !stop) state_next = RUN;
      end
      RUN: begin
        if (stop) state_next = STOPPING;
      end
      STOPPING: begin
        if (start && !stop) state_next = RUN;
        else if (frame_wrap) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (!scanning) begin
      h_next = '0;
      v_next = '0;
    end else if (en) begin
      if (h_wrap) begin
        h_next = '0;
        v_next = v_wrap ? '0 : v_cnt + WIDTH'(1);
      end else begin
        h_next = h_cnt + WIDTH'(1);
      end
    end
  end

  // Output decode straight from the count registers, gated by busy
  assign busy        = scanning;
  assign x           = h_cnt;
  assign y           = v_cnt;
  assign video_on    = scanning && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hsync       = (scanning && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END))
                       ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (scanning && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END))
                       ? SYNC_POL : ~SYNC_POL;
  assign frame_start = scanning && en && (h_cnt == '0) && (v_cnt == '0);
  assign line_end    = scanning && en && h_wrap;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl using a reduced raster (16x10) so whole
// frames, porches and sync windows can be walked cycle by cycle.
module tb_vga_timing_ctrl;

  localparam int W  = 10;
  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int VW = 2 * W + 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         hsync, vsync, video_on, frame_start, line_end, busy;
  logic [W-1:0] x, y;
  logic [VW-1:0] obs;
  logic [VW-1:0] exp_v;

  int checks = 0;
  int failures = 0;
  int eh = 0;
  int ev = 0;

  vga_timing_ctrl #(
    .WIDTH(W), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .x(x), .y(y),
    .frame_start(frame_start), .line_end(line_end), .busy(busy)
  );

  always #5 clk = ~clk;

  assign obs = {x, y, video_on, hsync, vsync, line_end, frame_start, busy};

  // Expected output vector for position (h,v), pixel tick e, busy b
  function automatic logic [VW-1:0] expv(input int h, input int v, input logic e, input logic b);
    logic vid, hs, vs, le, fs;
    if (!b) return {W'(0), W'(0), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vid = (h < HA) && (v < VA);
    hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    le  = e && (h == HT - 1);
    fs  = e && (h == 0) && (v == 0);
    return {W'(h), W'(v), vid, hs, vs, le, fs, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the expected raster position by one pixel tick
  task automatic adv();
    if (eh == HT - 1) begin
      eh = 0;
      ev = (ev == VT - 1) ? 0 : ev + 1;
    end else begin
      eh = eh + 1;
    end
  endtask

  task automatic test_reset();
    en = 1'b1;
    #1 rst = 1'b0;
    repeat (2) tick();
    #1;
    exp_v = expv(0, 0, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h", obs, exp_v);
    end
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL idle_without_start: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_full_frame();
    int fs_seen;
    fs_seen = 0;
    start = 1'b1;
    en = 1'b1;
    tick();
    start = 1'b0;
    eh = 0;
    ev = 0;
    for (int t = 0; t < HT * VT; t++) begin
      #1;
      exp_v = expv(eh, ev, 1'b1, 1'b1);
      if (frame_start === 1'b1) fs_seen++;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL full_frame t=%0d: got %h expected %h", t, obs, exp_v);
      end
      adv();
      tick();
    end
    #1;
    exp_v = expv(0, 0, 1'b1, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL frame_wrap: got %h expected %h", obs, exp_v);
    end
    checks++;
    if (fs_seen !== 1) begin
      failures++;
      $display("FAIL frame_start_count: got %0d expected 1", fs_seen);
    end
  endtask

  task automatic test_en_quarter();
    int fs_seen;
    fs_seen = 0;
    for (int c = 0; c < HT * VT * 4; c++) begin
      en = ((c % 4) == 0);
      #1;
      exp_v = expv(eh, ev, en, 1'b1);
      if (frame_start === 1'b1) fs_seen++;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL en_quarter c=%0d: got %h expected %h", c, obs, exp_v);
      end
      if (en) adv();
      tick();
    end
    checks++;
    if (fs_seen !== 1 || eh !== 0 || ev !== 0 || x !== W'(0) || y !== W'(0)) begin
      failures++;
      $display("FAIL en_quarter_period: got fs=%0d x=%0d y=%0d expected fs=1 x=0 y=0",
               fs_seen, x, y);
    end
    en = 1'b1;
  endtask

  task automatic test_stop_frame_end();
    for (int i = 0; i < 3 * HT + 5; i++) begin
      adv();
      tick();
    end
    stop = 1'b1;
    #1;
    exp_v = expv(eh, ev, 1'b1, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL stop_request_pos: got %h expected %h", obs, exp_v);
    end
    tick();
    adv();
    stop = 1'b0;
    while (!(eh == HT - 1 && ev == VT - 1)) begin
      #1;
      exp_v = expv(eh, ev, 1'b1, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL stopping_scan: got %h expected %h", obs, exp_v);
      end
      adv();
      tick();
    end
    #1;
    exp_v = expv(HT - 1, VT - 1, 1'b1, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL stopping_last_pixel: got %h expected %h", obs, exp_v);
    end
    tick();
    exp_v = expv(0, 0, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL stopped_idle: got %h expected %h", obs, exp_v);
    end
    repeat (3) tick();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL stopped_stays_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_cancel_stop();
    start = 1'b1;
    tick();
    start = 1'b0;
    eh = 0;
    ev = 0;
    for (int i = 0; i < HT + 2; i++) begin
      adv();
      tick();
    end
    stop = 1'b1;
    tick();
    adv();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adv();
      tick();
    end
    #1;
    exp_v = expv(6, 1, 1'b1, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL cancel_pos: got %h expected %h", obs, exp_v);
    end
    start = 1'b1;
    tick();
    adv();
    start = 1'b0;
    while (!(eh == 0 && ev == 0)) begin
      adv();
      tick();
    end
    #1;
    exp_v = expv(0, 0, 1'b1, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL cancel_keeps_running: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_start_stop_together();
    rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    exp_v = expv(0, 0, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL both_in_idle: got %h expected %h", obs, exp_v);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    eh = 0;
    ev = 0;
    #1;
    exp_v = expv(0, 0, 1'b1, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL restart_from_idle: got %h expected %h", obs, exp_v);
    end
    start = 1'b1;
    stop = 1'b1;
    tick();
    adv();
    start = 1'b0;
    stop = 1'b0;
    while (!(eh == 0 && ev == 0)) begin
      adv();
      tick();
    end
    exp_v = expv(0, 0, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL both_in_run_stops: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    eh = 0;
    ev = 0;
    for (int i = 0; i < 5 * HT + 11; i++) begin
      adv();
      tick();
    end
    #1;
    exp_v = expv(11, 5, 1'b1, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL pre_reset_pos: got %h expected %h", obs, exp_v);
    end
    #1 rst = 1'b0;
    #1;
    exp_v = expv(0, 0, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL async_reset: got %h expected %h", obs, exp_v);
    end
    #1 rst = 1'b1;
    tick();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL post_reset_idle: got %h expected %h", obs, exp_v);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    exp_v = expv(0, 0, 1'b1, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL restart_after_reset: got %h expected %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_en_quarter();
    test_stop_frame_end();
    test_cancel_stop();
    test_start_stop_together();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
